multicycle_control_fsm: RTL and testbench

- Moore-style control unit that sequences the team's multicycle MIPS `Data_Path`.
- Takes `OP`/`Funct` from the instruction register and `Zero` from the ALU.
- Drives every datapath control strobe, state by state, replacing testbench-driven control.
- Also exposes debug visibility: current state, instruction-complete pulse, retired-instruction counter.

---
 rtl/multicycle_control_fsm.sv | 227 ++++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Moore control FSM sequencing the multicycle MIPS datapath, with debug state/retire visibility.
// Optional illegal-opcode trap (HALT state, sticky illegal_op_o) enabled by macro ILLEGAL_OP_TRAP_EN.
module multicycle_control_fsm #(
   parameter int COUNT_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [5:0]             OP,
   input  logic [5:0]             Funct,
   input  logic                   Zero,
   output logic                   PCWrite,
   output logic                   IorD,
   output logic                   MemWrite,
   output logic                   IRWrite,
   output logic                   RegDst,
   output logic                   MemtoReg,
   output logic                   RegWrite,
   output logic                   ALUSrcA,
   output logic [1:0]             ALUSrcB,
   output logic [3:0]             ALUControl,
   output logic [1:0]             PCSrc,
   output logic [3:0]             state_o,
   output logic                   instr_done_o,
   output logic [COUNT_WIDTH-1:0] instr_count_o,
   output logic                   illegal_op_o
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTE  = 4'd6,
      S_ALUWB    = 4'd7,
      S_BRANCH   = 4'd8,
      S_IMMEXEC  = 4'd9,
      S_IMMWB    = 4'd10,
      S_JUMP     = 4'd11
`ifdef ILLEGAL_OP_TRAP_EN
      , S_HALT   = 4'd15
`endif
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_NOR = 4'b0010;
   localparam logic [3:0] ALU_ADD = 4'b0100;
   localparam logic [3:0] ALU_SUB = 4'b0101;
   localparam logic [3:0] ALU_SLT = 4'b0111;

   state_t state, state_next;

   logic       op_known;
   logic       funct_known;
   logic [3:0] funct_alu;
   logic       pc_write_raw, mem_write_raw, ir_write_raw, reg_write_raw;

   always_comb begin
      op_known = 1'b0;
      case (OP)
         OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: op_known = 1'b1;
         default:                                        op_known = 1'b0;
      endcase
   end

   always_comb begin
      funct_known = 1'b1;
      funct_alu   = ALU_ADD;
      case (Funct)
         6'h20:   funct_alu = ALU_ADD;
         6'h22:   funct_alu = ALU_SUB;
         6'h24:   funct_alu = ALU_AND;
         6'h25:   funct_alu = ALU_OR;
         6'h27:   funct_alu = ALU_NOR;
         6'h2A:   funct_alu = ALU_SLT;
         default: funct_known = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_FETCH;
      else       state <= state_next;
   end

   always_comb begin
      state_next = S_FETCH;
      case (state)
         S_FETCH:   state_next = S_DECODE;
         S_DECODE: begin
            case (OP)
               OP_LW, OP_SW: state_next = S_MEMADR;
               OP_RTYPE:     state_next = S_EXECUTE;
               OP_BEQ:       state_next = S_BRANCH;
               OP_ADDI:      state_next = S_IMMEXEC;
               OP_J:         state_next = S_JUMP;
`ifdef ILLEGAL_OP_TRAP_EN
               default:      state_next = S_HALT;
`else
               default:      state_next = S_FETCH;
`endif
            endcase
         end
         S_MEMADR:  state_next = (OP == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD: state_next = S_MEMWB;
`ifdef ILLEGAL_OP_TRAP_EN
         S_EXECUTE: state_next = funct_known ? S_ALUWB : S_HALT;
         S_HALT:    state_next = S_HALT;
`else
         S_EXECUTE: state_next = S_ALUWB;
`endif
         S_BRANCH:  state_next = S_FETCH;
         S_IMMEXEC: state_next = S_IMMWB;
         default:   state_next = S_FETCH;
      endcase
   end

   // Control strobes follow the state register; BRANCH additionally looks at Zero.
   always_comb begin
      pc_write_raw  = 1'b0;
      IorD          = 1'b0;
      mem_write_raw = 1'b0;
      ir_write_raw  = 1'b0;
      RegDst        = 1'b0;
      MemtoReg      = 1'b0;
      reg_write_raw = 1'b0;
      ALUSrcA       = 1'b0;
      ALUSrcB       = 2'b00;
      ALUControl    = 4'b0000;
      PCSrc         = 2'b00;
      instr_done_o  = 1'b0;
      case (state)
         S_FETCH: begin
            ir_write_raw = 1'b1;
            ALUSrcB      = 2'b01;
            ALUControl   = ALU_ADD;
            pc_write_raw = 1'b1;
         end
         S_DECODE: begin
            ALUSrcB    = 2'b11;
            ALUControl = ALU_ADD;
`ifndef ILLEGAL_OP_TRAP_EN
            instr_done_o = !op_known;
`endif
         end
         S_MEMADR: begin
            ALUSrcA    = 1'b1;
            ALUSrcB    = 2'b10;
            ALUControl = ALU_ADD;
         end
         S_MEMREAD: IorD = 1'b1;
         S_MEMWB: begin
            MemtoReg      = 1'b1;
            reg_write_raw = 1'b1;
            instr_done_o  = 1'b1;
         end
         S_MEMWRITE: begin
            IorD          = 1'b1;
            mem_write_raw = 1'b1;
            instr_done_o  = 1'b1;
         end
         S_EXECUTE: begin
            ALUSrcA    = 1'b1;
            ALUControl = funct_known ? funct_alu : ALU_ADD;
         end
         S_ALUWB: begin
            RegDst        = 1'b1;
            reg_write_raw = 1'b1;
            instr_done_o  = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA      = 1'b1;
            ALUControl   = ALU_SUB;
            PCSrc        = 2'b01;
            pc_write_raw = Zero;
            instr_done_o = 1'b1;
         end
         S_IMMEXEC: begin
            ALUSrcA    = 1'b1;
            ALUSrcB    = 2'b10;
            ALUControl = ALU_ADD;
         end
         S_IMMWB: begin
            reg_write_raw = 1'b1;
            instr_done_o  = 1'b1;
         end
         S_JUMP: begin
            PCSrc        = 2'b10;
            pc_write_raw = 1'b1;
            instr_done_o = 1'b1;
         end
         default: ;
      endcase
   end

   // Write enables are gated by reset so no architectural write escapes while it is held.
   assign PCWrite  = pc_write_raw  & ~reset;
   assign MemWrite = mem_write_raw & ~reset;
   assign IRWrite  = ir_write_raw  & ~reset;
   assign RegWrite = reg_write_raw & ~reset;
   assign state_o  = state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)             instr_count_o <= '0;
      else if (instr_done_o) instr_count_o <= instr_count_o + COUNT_WIDTH'(1);
   end

`ifdef ILLEGAL_OP_TRAP_EN
   logic illegal_q;
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                    illegal_q <= 1'b0;
      else if (state_next == S_HALT) illegal_q <= 1'b1;
   end
   assign illegal_op_o = illegal_q;
`else
   assign illegal_op_o = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: directed instructions, async reset, then random instruction mix
// checked cycle by cycle against a per-instruction state-sequence model and a control table.
module tb_multicycle_control_fsm;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [5:0]  OP = 6'h00;
   logic [5:0]  Funct = 6'h20;
   logic        Zero = 1'b0;
   logic        PCWrite, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
   logic [1:0]  ALUSrcB, PCSrc;
   logic [3:0]  ALUControl, state_o;
   logic        instr_done_o, illegal_op_o;
   logic [31:0] instr_count_o;

   int          total = 0;
   int          bad = 0;
   logic [31:0] exp_count = 0;
   logic        exp_illegal = 0;
   logic [3:0]  alu_map[int];
   bit          trap_en;

   multicycle_control_fsm #(.COUNT_WIDTH(32)) dut (
      .clk(clk), .reset(reset), .OP(OP), .Funct(Funct), .Zero(Zero),
      .PCWrite(PCWrite), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .PCSrc(PCSrc), .state_o(state_o),
      .instr_done_o(instr_done_o), .instr_count_o(instr_count_o), .illegal_op_o(illegal_op_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] alu_of(input logic [5:0] fn);
      return alu_map.exists(int'(fn)) ? alu_map[int'(fn)] : 4'b0100;
   endfunction

   // Expected control word {PCWrite,IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUControl,PCSrc}
   function automatic logic [15:0] exp_ctrl(input int s, input logic [5:0] fn, input logic z);
      logic pw, iord, mw, irw, rd, m2r, rw, sa;
      logic [1:0] sb, ps;
      logic [3:0] alu;
      {pw, iord, mw, irw, rd, m2r, rw, sa} = '0;
      sb = 2'b00; ps = 2'b00; alu = 4'b0000;
      case (s)
         0:  begin irw = 1; sb = 2'b01; alu = 4'b0100; pw = 1; end
         1:  begin sb = 2'b11; alu = 4'b0100; end
         2:  begin sa = 1; sb = 2'b10; alu = 4'b0100; end
         3:  iord = 1;
         4:  begin m2r = 1; rw = 1; end
         5:  begin iord = 1; mw = 1; end
         6:  begin sa = 1; alu = alu_of(fn); end
         7:  begin rd = 1; rw = 1; end
         8:  begin sa = 1; alu = 4'b0101; ps = 2'b01; pw = z; end
         9:  begin sa = 1; sb = 2'b10; alu = 4'b0100; end
         10: rw = 1;
         11: begin ps = 2'b10; pw = 1; end
         default: ;
      endcase
      return {pw, iord, mw, irw, rd, m2r, rw, sa, sb, alu, ps};
   endfunction

   function automatic logic [15:0] obs_ctrl();
      return {PCWrite, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
              ALUSrcB, ALUControl, PCSrc};
   endfunction

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rst_state", 32'(state_o), 32'd0);
      chk("rst_count", instr_count_o, 32'd0);
      chk("rst_illegal", 32'(illegal_op_o), 32'd0);
      chk("rst_ctrl", 32'(obs_ctrl()), 32'(exp_ctrl(0, 6'h20, 1'b0) & 16'h6FFF & ~16'h8000));
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      exp_count = 0;
      exp_illegal = 0;
   endtask

   // Runs one instruction from FETCH (called at a falling edge) and checks every cycle.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
      int  seq[$];
      bit  halts;
      bit  exp_done;
      halts = 0;
      seq = '{0, 1};
      case (op)
         6'h23: seq = '{0, 1, 2, 3, 4};
         6'h2B: seq = '{0, 1, 2, 5};
         6'h00: if (trap_en && !alu_map.exists(int'(fn))) halts = 1; else seq = '{0, 1, 6, 7};
         6'h08: seq = '{0, 1, 9, 10};
         6'h04: seq = '{0, 1, 8};
         6'h02: seq = '{0, 1, 11};
         default: if (trap_en) halts = 1;
      endcase
      if (halts) begin
         if (op == 6'h00) seq = '{0, 1, 6};
         for (int k = 0; k < 10; k++) seq.push_back(15);
      end
      OP = op; Funct = fn; Zero = z;
      for (int i = 0; i < seq.size(); i++) begin
         #1;
         exp_done = !halts && (i == seq.size() - 1);
         if (seq[i] == 15) exp_illegal = 1;
         chk($sformatf("state op=%0h c%0d", op, i), 32'(state_o), 32'(seq[i]));
         chk($sformatf("ctrl op=%0h c%0d", op, i), 32'(obs_ctrl()), 32'(exp_ctrl(seq[i], fn, z)));
         chk($sformatf("done op=%0h c%0d", op, i), 32'(instr_done_o), 32'(exp_done));
         chk($sformatf("count op=%0h c%0d", op, i), instr_count_o, exp_count);
         chk($sformatf("illegal op=%0h c%0d", op, i), 32'(illegal_op_o), 32'(exp_illegal));
         @(posedge clk);
         if (exp_done) exp_count = exp_count + 1;
         @(negedge clk);
      end
      if (halts) do_reset();
   endtask

   initial begin
      logic [5:0] ops[6];
      logic [5:0] fns[6];
      logic [5:0] op, fn;
`ifdef ILLEGAL_OP_TRAP_EN
      trap_en = 1;
`else
      trap_en = 0;
`endif
      alu_map[32'h20] = 4'b0100; alu_map[32'h22] = 4'b0101; alu_map[32'h24] = 4'b0000;
      alu_map[32'h25] = 4'b0001; alu_map[32'h27] = 4'b0010; alu_map[32'h2A] = 4'b0111;
      ops = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h02};
      fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};

      // Held in reset: FETCH outputs with write enables gated off.
      #2;
      chk("hold_state", 32'(state_o), 32'd0);
      chk("hold_pcwrite", 32'(PCWrite), 32'd0);
      chk("hold_irwrite", 32'(IRWrite), 32'd0);
      chk("hold_alusrcb", 32'(ALUSrcB), 32'd1);
      chk("hold_aluctl", 32'(ALUControl), 32'h4);
      chk("hold_count", instr_count_o, 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      run_instr(6'h23, 6'h00, 1'b0);
      run_instr(6'h00, 6'h22, 1'b0);
      run_instr(6'h04, 6'h00, 1'b1);
      run_instr(6'h04, 6'h00, 1'b0);
      run_instr(6'h2B, 6'h00, 1'b0);
      run_instr(6'h02, 6'h00, 1'b0);
      chk("count_after_directed", instr_count_o, 32'd6);

      // Reset asserted asynchronously while in MEMREAD.
      OP = 6'h23;
      @(posedge clk); @(posedge clk); @(posedge clk);
      @(negedge clk);
      chk("pre_rst_state", 32'(state_o), 32'd3);
      #2 reset = 1'b1;
      #1;
      chk("async_rst_state", 32'(state_o), 32'd0);
      chk("async_rst_regwrite", 32'(RegWrite), 32'd0);
      chk("async_rst_count", instr_count_o, 32'd0);
      @(posedge clk);
      #1;
      chk("rst_hold_regwrite", 32'(RegWrite), 32'd0);
      chk("rst_hold_state", 32'(state_o), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      exp_count = 0;
      #1;
      chk("post_rst_pcwrite", 32'(PCWrite), 32'd1);
      chk("post_rst_ctrl", 32'(obs_ctrl()), 32'(exp_ctrl(0, 6'h20, 1'b0)));

      run_instr(6'h3F, 6'h20, 1'b0);
      run_instr(6'h00, 6'h3F, 1'b1);

      for (int n = 0; n < 80; n++) begin
         op = ops[$urandom_range(0, 5)];
         if ($urandom_range(0, 5) == 0) op = 6'($urandom_range(0, 63));
         fn = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : fns[$urandom_range(0, 5)];
         run_instr(op, fn, 1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "time limit");
   end

endmodule
